// File: rtl/masku_operand_collector.sv
// Gathers one word per lane (any order, any cycle), assembles lane-interleaved beats
// and hands them to the mask unit through a small first-word-fall-through FIFO.
module masku_operand_collector #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [3:0]                   cfg_vsew_i,
  input  logic [15:0]                  cfg_nbeats_i,
  input  logic [NrLanes*DataWidth-1:0] lane_operand_i,
  input  logic [NrLanes-1:0]           lane_operand_valid_i,
  output logic [NrLanes-1:0]           lane_operand_ready_o,
  output logic [NrLanes*DataWidth-1:0] alu_operand_o,
  output logic [3:0]                   alu_vsew_o,
  output logic                         alu_last_o,
  output logic                         alu_valid_o,
  input  logic                         alu_ready_i
);

  localparam int unsigned BeatW = NrLanes * DataWidth;
  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           vsew_reg;
  logic [15:0]          remaining_reg;
  logic [DataWidth-1:0] lane_word_reg [NrLanes];
  logic [NrLanes-1:0]   lane_full_reg;
  logic [NrLanes-1:0]   lane_ready;
  logic [NrLanes-1:0]   lane_hs;
  logic [BeatW-1:0]     beat;

  logic [BeatW-1:0]     fifo_data_mem [FifoDepth];
  logic [3:0]           fifo_vsew_mem [FifoDepth];
  logic                 fifo_last_mem [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]      count_reg;

  logic fifo_empty, fifo_full, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FifoDepth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CntW'(FifoDepth));
  assign pop        = !fifo_empty && alu_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO does not stall assembly then.
  assign push       = (state_reg == COLLECT) && (&lane_full_reg) && (remaining_reg != 16'd0)
                      && (!fifo_full || pop);

  // Per-lane holding registers; readiness comes from registered lane_full only.
  for (genvar gi = 0; gi < NrLanes; gi++) begin : g_lane
    assign lane_ready[gi] = (state_reg == COLLECT) && !lane_full_reg[gi]
                            && (remaining_reg != 16'd0);
    assign lane_hs[gi]    = lane_ready[gi] && lane_operand_valid_i[gi];
    assign beat[gi*DataWidth +: DataWidth] = lane_word_reg[gi];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lane_word_reg[gi] <= '0;
        lane_full_reg[gi] <= 1'b0;
      end else begin
        if (lane_hs[gi]) lane_word_reg[gi] <= lane_operand_i[gi*DataWidth +: DataWidth];
        if (push)             lane_full_reg[gi] <= 1'b0;
        else if (lane_hs[gi]) lane_full_reg[gi] <= 1'b1;
      end
    end
  end

  assign lane_operand_ready_o = lane_ready;

  always_comb begin
    state_next  = state_reg;
    cfg_ready_o = (state_reg == IDLE);
    case (state_reg)
      IDLE:    if (cfg_valid_i && cfg_nbeats_i != 16'd0) state_next = COLLECT;
      COLLECT: if (push && remaining_reg == 16'd1) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      vsew_reg      <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cfg_valid_i) begin
        vsew_reg      <= cfg_vsew_i;
        remaining_reg <= cfg_nbeats_i;
      end else if (push) begin
        remaining_reg <= remaining_reg - 16'd1;
      end
    end
  end

  // Storage carries no reset; emptiness is tracked by count_reg alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= beat;
      fifo_vsew_mem[wr_ptr_reg] <= vsew_reg;
      fifo_last_mem[wr_ptr_reg] <= (remaining_reg == 16'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign alu_valid_o   = !fifo_empty;
  assign alu_operand_o = fifo_empty ? '0 : fifo_data_mem[rd_ptr_reg];
  assign alu_vsew_o    = fifo_empty ? '0 : fifo_vsew_mem[rd_ptr_reg];
  assign alu_last_o    = fifo_empty ? 1'b0 : fifo_last_mem[rd_ptr_reg];

endmodule

// File: tb/tb_masku_operand_collector.sv
// Randomised bench for masku_operand_collector: beat k of an instruction must be built
// from the k-th word each lane handed over, tagged with the configured vsew.
module tb_masku_operand_collector;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int FD = 2;
  localparam int BW = NL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_vsew;
  logic [15:0]   cfg_nbeats;
  logic [BW-1:0] lane_operand;
  logic [NL-1:0] lane_valid;
  logic [NL-1:0] lane_ready;
  logic [BW-1:0] alu_operand;
  logic [3:0]    alu_vsew;
  logic          alu_last;
  logic          alu_valid;
  logic          alu_ready;

  always #5 clk = ~clk;

  masku_operand_collector #(.NrLanes(NL), .DataWidth(DW), .FifoDepth(FD)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_vsew_i(cfg_vsew), .cfg_nbeats_i(cfg_nbeats),
    .lane_operand_i(lane_operand), .lane_operand_valid_i(lane_valid),
    .lane_operand_ready_o(lane_ready),
    .alu_operand_o(alu_operand), .alu_vsew_o(alu_vsew), .alu_last_o(alu_last),
    .alu_valid_o(alu_valid), .alu_ready_i(alu_ready)
  );

  typedef struct packed {
    logic [BW-1:0] data;
    logic [3:0]    vsew;
    logic          last;
  } beat_t;

  // Model: words[k][l] is the k-th word lane l offers; idx[l] counts its accepted words.
  logic [DW-1:0] words [64][NL];
  int            idx [NL];
  int            nb_cur;
  logic [3:0]    vsew_cur;
  beat_t         obs_q[$];
  int            n_compared = 0;
  int            n_mismatched = 0;

  function automatic logic [BW-1:0] exp_beat(input int k);
    logic [BW-1:0] b;
    for (int l = 0; l < NL; l++) b[l*DW +: DW] = words[k][l];
    return b;
  endfunction

  task automatic start_cfg(input logic [3:0] vsew, input int nb);
    vsew_cur = vsew;
    nb_cur   = nb;
    obs_q.delete();
    for (int k = 0; k < 64; k++)
      for (int l = 0; l < NL; l++) words[k][l] = {$urandom, $urandom};
    for (int l = 0; l < NL; l++) idx[l] = 0;
    lane_valid = '0;
    cfg_vsew   = vsew;
    cfg_nbeats = 16'(nb);
    cfg_valid  = 1'b1;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
  endtask

  task automatic present(input logic [NL-1:0] mask);
    for (int l = 0; l < NL; l++)
      if (mask[l]) begin
        lane_valid[l] = 1'b1;
        lane_operand[l*DW +: DW] = words[idx[l]][l];
      end
  endtask

  // One clock: observe handshakes at negedge, update drives just after posedge.
  task automatic drive_cycle(input int vp, input int rp, input logic [NL-1:0] mask);
    logic [NL-1:0] hs;
    @(negedge clk);
    hs = lane_valid & lane_ready;
    if (alu_valid && alu_ready) obs_q.push_back(beat_t'({alu_operand, alu_vsew, alu_last}));
    @(posedge clk); #1;
    for (int l = 0; l < NL; l++) begin
      if (hs[l]) begin
        idx[l]++;
        lane_valid[l] = 1'b0;
      end
      if (!lane_valid[l] && mask[l] && idx[l] < nb_cur && int'($urandom_range(99)) < vp)
        lane_valid[l] = 1'b1;
      lane_operand[l*DW +: DW] = words[idx[l]][l];
    end
    alu_ready = (int'($urandom_range(99)) < rp);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_compared++;
    if ({cfg_ready, lane_ready, alu_valid, alu_vsew, alu_last} !== {1'b1, 4'b0, 1'b0, 4'b0, 1'b0}) begin
      n_mismatched++;
      $display("FAIL reset_ctrl: got rdy=%b lr=%b v=%b vsew=%h last=%b", cfg_ready, lane_ready, alu_valid, alu_vsew, alu_last);
    end
    n_compared++;
    if (alu_operand !== '0) begin
      n_mismatched++;
      $display("FAIL reset_operand: got %h want 0", alu_operand);
    end
    start_cfg(4'd0, 4);
    alu_ready = 1'b1;
    present(4'b0011);
    drive_cycle(0, 100, 4'b0011);
    n_compared++;
    if (lane_ready !== 4'b1100) begin
      n_mismatched++;
      $display("FAIL reset_partial_ready: got %b want 1100", lane_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lane_valid = '0;
    n_compared++;
    if ({lane_ready, alu_valid, cfg_ready} !== {4'b0, 1'b0, 1'b1}) begin
      n_mismatched++;
      $display("FAIL reset_midop: got lr=%b v=%b cfg_rdy=%b want 0000 0 1", lane_ready, alu_valid, cfg_ready);
    end
  endtask

  task automatic test_in_order;
    start_cfg(4'd2, 1);
    for (int l = 0; l < NL; l++) words[0][l] = 64'(l);
    alu_ready = 1'b1;
    present(4'hF);
    n_compared++;
    if (lane_ready !== 4'hF) begin
      n_mismatched++;
      $display("FAIL inorder_ready: got %b want 1111", lane_ready);
    end
    drive_cycle(0, 100, 4'hF);
    n_compared++;
    if (alu_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL inorder_early_valid: got %b want 0", alu_valid);
    end
    drive_cycle(0, 100, 4'hF);
    n_compared++;
    if ({alu_valid, alu_operand, alu_vsew, alu_last} !== {1'b1, exp_beat(0), 4'd2, 1'b1}) begin
      n_mismatched++;
      $display("FAIL inorder_beat: got v=%b %h vsew=%h last=%b want v=1 %h vsew=2 last=1", alu_valid, alu_operand, alu_vsew, alu_last, exp_beat(0));
    end
    drive_cycle(0, 100, 4'hF);
    n_compared++;
    if ({alu_valid, cfg_ready} !== 2'b00) begin
      n_mismatched++;
      $display("FAIL inorder_drain: got v=%b cfg_rdy=%b want 0 0", alu_valid, cfg_ready);
    end
    drive_cycle(0, 100, 4'hF);
    n_compared++;
    if (cfg_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL inorder_idle: got cfg_rdy=%b want 1", cfg_ready);
    end
  endtask

  task automatic test_skewed;
    start_cfg(4'd1, 2);
    alu_ready = 1'b1;
    present(4'b1011);
    for (int c = 1; c <= 4; c++) begin
      drive_cycle(100, 100, 4'b1011);
      n_compared++;
      if ({lane_ready, alu_valid} !== {4'b0100, 1'b0}) begin
        n_mismatched++;
        $display("FAIL skew_hold_c%0d: got lr=%b v=%b want 0100 0", c, lane_ready, alu_valid);
      end
    end
    drive_cycle(100, 100, 4'hF);
    drive_cycle(100, 100, 4'hF);
    n_compared++;
    if ({lane_ready, alu_valid} !== {4'b0000, 1'b0}) begin
      n_mismatched++;
      $display("FAIL skew_all_full: got lr=%b v=%b want 0000 0", lane_ready, alu_valid);
    end
    drive_cycle(100, 100, 4'hF);
    n_compared++;
    if ({alu_valid, alu_operand, alu_last} !== {1'b1, exp_beat(0), 1'b0}) begin
      n_mismatched++;
      $display("FAIL skew_beat0: got v=%b %h last=%b want v=1 %h last=0", alu_valid, alu_operand, alu_last, exp_beat(0));
    end
    drive_cycle(100, 100, 4'hF);
    drive_cycle(100, 100, 4'hF);
    n_compared++;
    if ({alu_valid, alu_operand, alu_last} !== {1'b1, exp_beat(1), 1'b1}) begin
      n_mismatched++;
      $display("FAIL skew_beat1: got v=%b %h last=%b want v=1 %h last=1", alu_valid, alu_operand, alu_last, exp_beat(1));
    end
    for (int c = 0; c < 10 && !cfg_ready; c++) drive_cycle(100, 100, 4'hF);
    n_compared++;
    if (cfg_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL skew_idle: got cfg_rdy=%b want 1", cfg_ready);
    end
  endtask

  task automatic test_backpressure;
    start_cfg(4'd3, 4);
    alu_ready = 1'b0;
    repeat (12) drive_cycle(100, 0, 4'hF);
    n_compared++;
    if ({alu_valid, lane_ready, alu_operand} !== {1'b1, 4'b0, exp_beat(0)}) begin
      n_mismatched++;
      $display("FAIL bp_stall: got v=%b lr=%b %h want v=1 lr=0000 %h", alu_valid, lane_ready, alu_operand, exp_beat(0));
    end
    for (int l = 0; l < NL; l++) begin
      n_compared++;
      if (idx[l] != 3) begin
        n_mismatched++;
        $display("FAIL bp_lane%0d_words: got %0d accepted want 3", l, idx[l]);
      end
    end
    repeat (3) drive_cycle(100, 0, 4'hF);
    n_compared++;
    if ({alu_operand, alu_vsew, alu_last} !== {exp_beat(0), 4'd3, 1'b0}) begin
      n_mismatched++;
      $display("FAIL bp_stable: got %h vsew=%h last=%b want %h vsew=3 last=0", alu_operand, alu_vsew, alu_last, exp_beat(0));
    end
    for (int c = 0; c < 60 && !(obs_q.size() == 4 && cfg_ready); c++) drive_cycle(100, 100, 4'hF);
    n_compared++;
    if (obs_q.size() != 4) begin
      n_mismatched++;
      $display("FAIL bp_count: got %0d beats want 4", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 4; k++) begin
      n_compared++;
      if (obs_q[k] !== beat_t'({exp_beat(k), 4'd3, (k == 3)})) begin
        n_mismatched++;
        $display("FAIL bp_beat%0d: got %h want %h", k, obs_q[k], beat_t'({exp_beat(k), 4'd3, (k == 3)}));
      end
    end
  endtask

  task automatic test_zero_and_busy;
    start_cfg(4'd1, 0);
    for (int c = 0; c < 4; c++) begin
      drive_cycle(100, 100, 4'hF);
      n_compared++;
      if ({alu_valid, cfg_ready, lane_ready} !== {1'b0, 1'b1, 4'b0}) begin
        n_mismatched++;
        $display("FAIL zero_len_c%0d: got v=%b cfg_rdy=%b lr=%b want 0 1 0000", c, alu_valid, cfg_ready, lane_ready);
      end
    end
    start_cfg(4'd1, 2);
    drive_cycle(0, 100, 4'hF);
    cfg_valid  = 1'b1;
    cfg_vsew   = 4'd3;
    cfg_nbeats = 16'd9;
    n_compared++;
    if (cfg_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL busy_cfg_ready: got %b want 0", cfg_ready);
    end
    drive_cycle(100, 100, 4'hF);
    cfg_valid = 1'b0;
    for (int c = 0; c < 100 && !(obs_q.size() == 2 && cfg_ready); c++) drive_cycle(70, 70, 4'hF);
    n_compared++;
    if (obs_q.size() != 2) begin
      n_mismatched++;
      $display("FAIL busy_count: got %0d beats want 2", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 2; k++) begin
      n_compared++;
      if (obs_q[k] !== beat_t'({exp_beat(k), 4'd1, (k == 1)})) begin
        n_mismatched++;
        $display("FAIL busy_beat%0d: got %h want %h", k, obs_q[k], beat_t'({exp_beat(k), 4'd1, (k == 1)}));
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 4; it++) begin
      int nb;
      int lasts;
      nb = int'($urandom_range(1, 6));
      start_cfg(4'($urandom_range(0, 3)), nb);
      for (int c = 0; c < 400 && !(obs_q.size() == nb && cfg_ready); c++) drive_cycle(60, 60, 4'hF);
      n_compared++;
      if (obs_q.size() != nb) begin
        n_mismatched++;
        $display("FAIL b2b%0d_count: got %0d beats want %0d", it, obs_q.size(), nb);
      end
      lasts = 0;
      for (int k = 0; k < obs_q.size() && k < nb; k++) begin
        lasts += int'(obs_q[k].last);
        n_compared++;
        if (obs_q[k] !== beat_t'({exp_beat(k), vsew_cur, (k == nb - 1)})) begin
          n_mismatched++;
          $display("FAIL b2b%0d_beat%0d: got %h want %h", it, k, obs_q[k], beat_t'({exp_beat(k), vsew_cur, (k == nb - 1)}));
        end
      end
      n_compared++;
      if (lasts != 1) begin
        n_mismatched++;
        $display("FAIL b2b%0d_last_count: got %0d want 1", it, lasts);
      end
    end
  endtask

  task automatic test_push_pop_full;
    start_cfg(4'($urandom_range(0, 3)), 16);
    alu_ready = 1'b0;
    repeat (12) drive_cycle(100, 0, 4'hF);
    n_compared++;
    if ({alu_valid, lane_ready} !== {1'b1, 4'b0}) begin
      n_mismatched++;
      $display("FAIL ppf_full: got v=%b lr=%b want 1 0000", alu_valid, lane_ready);
    end
    drive_cycle(100, 100, 4'hF);
    drive_cycle(100, 0, 4'hF);
    n_compared++;
    if ({obs_q.size() == 1, alu_valid, alu_operand, lane_ready} !== {1'b1, 1'b1, exp_beat(1), 4'hF}) begin
      n_mismatched++;
      $display("FAIL ppf_swap: got pops=%0d v=%b %h lr=%b want 1 1 %h 1111", obs_q.size(), alu_valid, alu_operand, lane_ready, exp_beat(1));
    end
    repeat (6) drive_cycle(100, 0, 4'hF);
    for (int l = 0; l < NL; l++) begin
      n_compared++;
      if (idx[l] != 4) begin
        n_mismatched++;
        $display("FAIL ppf_lane%0d_words: got %0d accepted want 4", l, idx[l]);
      end
    end
    for (int c = 0; c < 800 && !(obs_q.size() == 16 && cfg_ready); c++)
      drive_cycle(int'($urandom_range(30, 100)), 50, 4'hF);
    n_compared++;
    if (obs_q.size() != 16) begin
      n_mismatched++;
      $display("FAIL ppf_count: got %0d beats want 16", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 16; k++) begin
      n_compared++;
      if (obs_q[k] !== beat_t'({exp_beat(k), vsew_cur, (k == 15)})) begin
        n_mismatched++;
        $display("FAIL ppf_beat%0d: got %h want %h", k, obs_q[k], beat_t'({exp_beat(k), vsew_cur, (k == 15)}));
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_valid    = 1'b0;
    cfg_vsew     = '0;
    cfg_nbeats   = '0;
    lane_operand = '0;
    lane_valid   = '0;
    alu_ready    = 1'b0;
    nb_cur       = 0;
    vsew_cur     = '0;
    test_reset();
    test_in_order();
    test_skewed();
    test_backpressure();
    test_zero_and_busy();
    test_back_to_back();
    test_push_pop_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/masku_operand_collector.md
Name: masku_operand_collector

Overview:
- Sits directly upstream of the mask unit's element-order operand sequencer.
- Collects one DataWidth word per lane from the lane sequencers. Lanes may deliver in any order and on different cycles.
- Once every lane has delivered, assembles one NrLanes*DataWidth lane-interleaved beat. The beat is tagged with the latched vsew and a last flag.
- Buffers assembled beats in a small FIFO and presents them with valid/ready to the sequencer and the mask ALU.

Parameters:
- NrLanes, 4, number of lanes; legal values 2, 4, 8, 16.
- DataWidth, 64, width of one lane word (ELEN).
- FifoDepth, 2, number of assembled beats buffered; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_valid_i  in  1  new instruction configuration valid.
- cfg_ready_o  out  1  configuration accepted; high only in IDLE.
- cfg_vsew_i  in  4  element width encoding (EW8/EW16/EW32/EW64).
- cfg_nbeats_i  in  16  number of full-width beats to collect.
- lane_operand_i  in  NrLanes*DataWidth  per-lane words; lane l occupies bits [l*DataWidth +: DataWidth].
- lane_operand_valid_i  in  NrLanes  per-lane valid.
- lane_operand_ready_o  out  NrLanes  per-lane ready.
- alu_operand_o  out  NrLanes*DataWidth  assembled beat, lane-interleaved, unreordered.
- alu_vsew_o  out  4  vsew tag of the beat.
- alu_last_o  out  1  high on the final beat of the instruction.
- alu_valid_o  out  1  beat valid.
- alu_ready_i  in  1  consumer accepts the beat.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE; lane holding regs, lane_full, counters and FIFO cleared.
  - Outputs: cfg_ready_o=1, lane_operand_ready_o=0, alu_valid_o=0, alu_operand_o=0, alu_vsew_o=0, alu_last_o=0.
  - Reset mid-operation discards all partial and buffered data.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - cfg_ready_o=1.
  - On cfg_valid_i: latch vsew, set remaining=cfg_nbeats_i.
  - If cfg_nbeats_i==0, stay IDLE and produce no output. Otherwise go to COLLECT.
- COLLECT:
  - lane_operand_ready_o[l] = !lane_full[l] && remaining!=0.
  - A lane handshake (valid&&ready) stores that word and sets lane_full[l].
  - A lane with lane_full set is never overwritten.
- Assembly:
  - Occurs in any cycle where all lane_full bits are set (registered state) and the FIFO is not full.
  - Pushes {words, vsew, last=(remaining==1)}, clears all lane_full, decrements remaining.
  - The same cycle's lane handshakes for the next beat are blocked, because ready is derived from the registered lane_full.
  - When the push makes remaining 0, go to DRAIN.
- Latency: last lane handshake in cycle N, push at end of N+1, alu_valid_o high in N+2 (when FIFO was empty and no backpressure).
- FIFO:
  - First-word-fall-through; alu_* reflect the head entry.
  - Pop on alu_valid_o && alu_ready_i.
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot that cycle).
  - When full, assembly stalls: lane_full bits stay set, and ready stays low for full lanes.
- Output stability: while alu_valid_o && !alu_ready_i, alu_operand_o, alu_vsew_o and alu_last_o hold constant.
- DRAIN:
  - Lane readies 0, cfg_ready_o=0.
  - Go to IDLE in the cycle after the FIFO becomes empty, i.e. after the last beat's pop.
- cfg_valid_i outside IDLE is ignored (cfg_ready_o=0).
- remaining is 16-bit unsigned. It never wraps: decrement only on push with remaining!=0.
- alu_last_o is asserted exactly once per non-zero instruction.

Test Plan:
- Reset: assert rst_i while lanes are mid-collection (2 of 4 lane_full set) -> next cycle all lane readies 0, alu_valid_o=0, cfg_ready_o=1, FIFO empty.
- In-order single beat: NrLanes=4, cfg vsew=EW32, nbeats=1; lanes 0..3 present 64'h0..0_L all in cycle 0 with alu_ready_i=1 -> alu_valid_o=1 in cycle 2, alu_operand_o={lane3,lane2,lane1,lane0}, alu_last_o=1, alu_vsew_o=EW32; IDLE by cycle 4.
- Skewed lanes: nbeats=2; lane 2 valid 5 cycles after the others -> no beat until lane 2's handshake+2; lanes 0,1,3 ready low while holding; second beat has alu_last_o=1, first has 0.
- Backpressure: nbeats=4, FifoDepth=2, alu_ready_i=0 -> exactly 2 beats buffered, third beat held in lane regs, lane readies 0; releasing alu_ready_i delivers 4 beats in order with unchanged data, last on beat 4.
- Zero length and busy config: cfg nbeats=0 -> accepted, no alu_valid_o, stays IDLE. A cfg_valid_i pulse during COLLECT -> cfg_ready_o=0, latched vsew/remaining unchanged.
- Simultaneous push/pop at full: FIFO full, alu_ready_i=1 and all lanes full in the same cycle -> one pop and one push that cycle; occupancy stays 2; no beat lost or duplicated (check with a scoreboard over 16 beats and random lane valids).
